// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar control unit: state codes, frame length
// and a width helper for the timeout counters.
package sonar_pkg;

  typedef enum logic [3:0] {
    IDLE           = 4'd0,
    PREPARA        = 4'd1,
    ESPERA_2S      = 4'd2,
    MEDE           = 4'd3,
    AGUARDA_MEDIDA = 4'd4,
    TRANSMITE      = 4'd5,
    AGUARDA_SERIAL = 4'd6,
    PROX_CHAR      = 4'd7,
    PROX_POS       = 4'd8
  } state_e;

  localparam int SONAR_N_CHARS = 8;

  // $clog2 collapses to 0 for tiny limits; keep at least one counter bit
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sonar_uc_if.sv
// Control/status bundle between sonar_uc and the sonar_fd datapath.
interface sonar_uc_if;
  logic       ligar;
  logic       tick_2s;
  logic       sensor_pronto;
  logic       serial_pronto;
  logic       medicao;
  logic       transmissao;
  logic       limpa_tick_2s;
  logic       conta_tick_2s;
  logic [2:0] sel_posicao;
  logic [2:0] sel_rom;
  logic [2:0] sel_transmissao;
  logic       erro;
  logic       pronto;
  logic [3:0] db_estado;

  modport master (
    input  ligar, tick_2s, sensor_pronto, serial_pronto,
    output medicao, transmissao, limpa_tick_2s, conta_tick_2s,
           sel_posicao, sel_rom, sel_transmissao, erro, pronto, db_estado
  );

  modport slave (
    output ligar, tick_2s, sensor_pronto, serial_pronto,
    input  medicao, transmissao, limpa_tick_2s, conta_tick_2s,
           sel_posicao, sel_rom, sel_transmissao, erro, pronto, db_estado
  );
endinterface

// File: rtl/sonar_watchdog.sv
// Saturating clear/enable counter; tc is high once TIMEOUT-1 has been reached.
module sonar_watchdog
  import sonar_pkg::*;
#(
  parameter int TIMEOUT = 1_250_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int W = cnt_w(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear)            cnt <= '0;
    else if (enable && cnt != LAST) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == LAST);
endmodule

// File: rtl/sonar_uc.sv
// Sonar sweep/measure/transmit controller (Moore FSM). Index registers are
// updated on entry to the state that owns them, so outputs decode directly.
module sonar_uc
  import sonar_pkg::*;
#(
  parameter int N_CHARS = SONAR_N_CHARS,
  parameter int N_POS   = 8,
  parameter int TIMEOUT = 1_250_000
) (
  input  logic      clock,
  input  logic      reset,
  sonar_uc_if.master bus
);
  localparam logic [3:0] S_IDLE      = 4'(IDLE);
  localparam logic [3:0] S_PREPARA   = 4'(PREPARA);
  localparam logic [3:0] S_ESPERA    = 4'(ESPERA_2S);
  localparam logic [3:0] S_MEDE      = 4'(MEDE);
  localparam logic [3:0] S_AG_MEDIDA = 4'(AGUARDA_MEDIDA);
  localparam logic [3:0] S_TRANSMITE = 4'(TRANSMITE);
  localparam logic [3:0] S_AG_SERIAL = 4'(AGUARDA_SERIAL);
  localparam logic [3:0] S_PROX_CHAR = 4'(PROX_CHAR);
  localparam logic [3:0] S_PROX_POS  = 4'(PROX_POS);

  localparam logic [2:0] LAST_CHAR = 3'(N_CHARS - 1);
  localparam logic [2:0] LAST_POS  = 3'(N_POS - 1);

  logic [3:0] state, nxt;
  logic [2:0] pos, pos_step, chr;
  logic       dir_up, erro_q, wd_tc;

  sonar_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == S_MEDE),
    .enable (state == S_AG_MEDIDA),
    .tc     (wd_tc)
  );

  always_comb begin
    nxt = state;
    if (state != S_IDLE && !bus.ligar) nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:      if (bus.ligar) nxt = S_PREPARA;
        S_PREPARA:   nxt = S_ESPERA;
        S_ESPERA:    if (bus.tick_2s) nxt = S_MEDE;
        S_MEDE:      nxt = S_AG_MEDIDA;
        // a simultaneous sensor_pronto beats the timeout
        S_AG_MEDIDA: if (bus.sensor_pronto) nxt = S_TRANSMITE;
                     else if (wd_tc)        nxt = S_PROX_POS;
        S_TRANSMITE: nxt = S_AG_SERIAL;
        S_AG_SERIAL: if (bus.serial_pronto) nxt = S_PROX_CHAR;
        S_PROX_CHAR: nxt = (chr == LAST_CHAR) ? S_PROX_POS : S_TRANSMITE;
        S_PROX_POS:  nxt = S_ESPERA;
        default:     nxt = S_IDLE;
      endcase
    end
  end

  assign pos_step = dir_up ? pos + 3'd1 : pos - 3'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      pos    <= '0;
      dir_up <= 1'b1;
      chr    <= '0;
      erro_q <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt == S_PREPARA) begin
        pos    <= '0;
        dir_up <= 1'b1;
        chr    <= '0;
      end
      if (nxt == S_MEDE) erro_q <= 1'b0;
      if (state == S_AG_MEDIDA && nxt == S_PROX_POS) erro_q <= 1'b1;
      if (state == S_PROX_CHAR && nxt == S_TRANSMITE) chr <= chr + 3'd1;
      // ping-pong sweep: direction turns at either end
      if (nxt == S_PROX_POS) begin
        chr <= '0;
        pos <= pos_step;
        if (pos_step == LAST_POS) dir_up <= 1'b0;
        else if (pos_step == 3'd0) dir_up <= 1'b1;
      end
    end
  end

  assign bus.medicao         = (state == S_MEDE);
  assign bus.transmissao     = (state == S_TRANSMITE);
  assign bus.limpa_tick_2s   = (state == S_PREPARA) || (state == S_PROX_POS);
  assign bus.conta_tick_2s   = (state == S_ESPERA);
  assign bus.sel_posicao     = pos;
  assign bus.sel_rom         = pos;
  assign bus.sel_transmissao = chr;
  assign bus.erro            = erro_q;
  assign bus.pronto          = (state == S_PROX_POS) && (pos == 3'd0);
  assign bus.db_estado       = state;
endmodule

// File: doc/sonar_uc.md
# sonar_uc

Control unit for the sonar datapath `sonar_fd`. It sweeps the servo through its angle positions and waits the 2 s dwell at each one. It then fires one ultrasonic measurement and serializes the result as a fixed-length ASCII frame, driving the `sonar_fd` control inputs one character at a time. This Moore FSM is the only driver of `medicao`, `transmissao`, the tick-2s counter controls and the three select buses.

## Interface
Parameters:
- `N_CHARS`, 8: characters per frame: 3 angle digits, ',', 3 distance digits, '#'. Range 1..8.
- `N_POS`, 8: servo positions. Index range 0..N_POS-1. Range 2..8.
- `TIMEOUT`, 1_250_000: cycles to wait for `sensor_pronto`. 25 ms at 50 MHz.

Ports:
- `clock` in 1: single clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `ligar` in 1: run enable, level-sensitive.
- `tick_2s` in 1: end of the 2 s dwell, from `sonar_fd`.
- `sensor_pronto` in 1: measurement done, from `sonar_fd`.
- `serial_pronto` in 1: character sent, from `sonar_fd`.
- `medicao` out 1: start measurement, 1-cycle pulse.
- `transmissao` out 1: start character transmission, 1-cycle pulse.
- `limpa_tick_2s` out 1: clears the tick-2s counter.
- `conta_tick_2s` out 1: enables the tick-2s counter.
- `sel_posicao` out 3: current servo position index.
- `sel_rom` out 3: angle ROM address. Always equal to `sel_posicao`.
- `sel_transmissao` out 3: current character index within the frame.
- `erro` out 1: the last measurement timed out.
- `pronto` out 1: 1-cycle pulse when the sweep returns to index 0.
- `db_estado` out 4: current state code.

## Operation
States and codes:
- IDLE (0): if `ligar` → PREPARA.
- PREPARA (1): `limpa_tick_2s`=1. Set position index 0, direction up, character index 0. → ESPERA_2S.
- ESPERA_2S (2): `conta_tick_2s`=1. If `tick_2s` → MEDE.
- MEDE (3): `medicao`=1. Clear `erro` and the watchdog. → AGUARDA_MEDIDA.
- AGUARDA_MEDIDA (4): watchdog counts.
  - If `sensor_pronto` → TRANSMITE.
  - Else if the watchdog reaches TIMEOUT-1 → set `erro`, go to PROX_POS. The frame is skipped.
- TRANSMITE (5): `transmissao`=1. → AGUARDA_SERIAL.
- AGUARDA_SERIAL (6): if `serial_pronto` → PROX_CHAR.
- PROX_CHAR (7): if character index = N_CHARS-1 → PROX_POS. Otherwise increment the index and go to TRANSMITE.
- PROX_POS (8): `limpa_tick_2s`=1. Reset the character index to 0 and step the position. → ESPERA_2S.

Position stepping:
- The sweep ping-pongs: 0,1,…,N_POS-1,N_POS-2,…,0,1,…
- The direction flips to down upon reaching N_POS-1 and to up upon reaching 0.
- `pronto` is high in the PROX_POS cycle whose update makes the index 0.

Boundary rules:
- `ligar` low in any non-IDLE state → IDLE on the next edge. Counters and indices are not cleared until PREPARA. No partial-frame completion.
- Inputs are sampled only in the states listed above; `tick_2s`, `sensor_pronto` and `serial_pronto` are ignored elsewhere.
- If `sensor_pronto` and the timeout occur in the same cycle, `sensor_pronto` wins and `erro` stays 0.
- `erro` is sticky until the next MEDE.

## Timing
- Outputs are Moore-decoded from the state and index registers; there are no input-to-output combinational paths.
- Reset: state IDLE and every output 0; `db_estado`=0; internal direction up.
- Reset has priority over all transitions and takes effect in any state.
- `ligar` high at edge n: PREPARA at n+1, ESPERA_2S with `conta_tick_2s`=1 at n+2.
- `tick_2s` sampled at edge m: `medicao` high during cycle m+1 only.
- `sensor_pronto` sampled at edge k: `transmissao` high during cycle k+1 with `sel_transmissao`=0.
- `sel_transmissao` is stable from TRANSMITE through AGUARDA_SERIAL.
- Inter-character gap: `serial_pronto` at edge j → next `transmissao` at cycle j+2.
- The watchdog counter is $clog2(TIMEOUT) bits wide and saturates. A timeout is declared TIMEOUT cycles after entering AGUARDA_MEDIDA.

## Structure
- Package `sonar_pkg`: state enum with the codes above; default frame length constant `SONAR_N_CHARS`=8.
- Sub-module `sonar_watchdog`: clear/enable/terminal-count counter parameterized by TIMEOUT. Reused later for echo timeout.
- Position/direction and character index logic stay inline in `sonar_uc`.

## Test plan
- Reset mid-AGUARDA_SERIAL → all outputs 0 and `db_estado`=0 at the next edge. `ligar`=1 → PREPARA then ESPERA_2S with `conta_tick_2s`=1.
- Full frame with N_CHARS=8:
  - Sequence: `tick_2s`, then `sensor_pronto` 100 cycles later, then each `serial_pronto` 50 cycles after its `transmissao`.
  - Required: 8 `transmissao` pulses with `sel_transmissao` 0..7, then PROX_POS with `sel_posicao`=1 and `limpa_tick_2s`=1.
- Sweep with N_POS=8 over 16 frames: `sel_posicao` sequence 0,1,…,7,6,…,0,1. `pronto` pulses exactly once, on return to 0. `sel_rom` equals `sel_posicao` throughout.
- Timeout with TIMEOUT=100 and no `sensor_pronto`: `erro`=1 exactly 100 cycles after entering AGUARDA_MEDIDA, no `transmissao`, position advances. The next MEDE clears `erro`.
- `sensor_pronto` on the timeout cycle → TRANSMITE and `erro`=0.
- `ligar` dropped during TRANSMITE → IDLE next edge. No further pulses; `serial_pronto` pulses are ignored.
